adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit; the next generation of the team's ripple-carry adder. Operand width is split into SEG-bit segments, one per pipeline stage, with the carry registered between stages. This keeps the ripple-carry critical path bounded for ALU use at any width. A valid/ready handshake with backpressure lets it sit between the execute-stage operand mux and writeback, and it reports carry, signed overflow and zero.

---
 rtl/adder_pipe_pkg.sv | 16 +
 rtl/adder_pipe_stage.sv | 72 +++++++
 rtl/adder_pipe.sv | 80 ++++++++
 tb/tb_adder_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder.
package adder_pipe_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of pipeline stages; 0 flags an illegal WIDTH/SEG pairing so the
    // top level can refuse to elaborate.
    function automatic int calc_stages(input int width, input int seg);
        if (seg < 1 || width < seg || (width % seg) != 0) begin
            return 0;
        end
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: adds segment IDX of the operands plus the incoming carry
// and registers the partially built result alongside the remaining operands.
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int SEG   = 32,
    parameter int WIDTH = 64,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic             i_carry,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_valid,
    output logic             o_carry,
    output logic             o_ovf,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y
);

    // i_x holds finished sum segments below IDX and unconsumed A segments from
    // IDX upward; i_y carries the (possibly inverted) B operand.
    logic [SEG-1:0]   w_seg_a;
    logic [SEG-1:0]   w_seg_b;
    logic [SEG-1:0]   w_seg_sum;
    logic             w_carry_out;
    logic             w_carry_msb;
    logic [WIDTH-1:0] w_x_next;

    logic             r_valid;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    always_comb begin
        w_seg_a = i_x[IDX*SEG +: SEG];
        w_seg_b = i_y[IDX*SEG +: SEG];
        {w_carry_out, w_seg_sum} = {1'b0, w_seg_a} + {1'b0, w_seg_b}
                                 + {{SEG{1'b0}}, i_carry};
        // Carry into the segment MSB, recovered from the sum bit.
        w_carry_msb = w_seg_sum[SEG-1] ^ w_seg_a[SEG-1] ^ w_seg_b[SEG-1];
        w_x_next = i_x;
        w_x_next[IDX*SEG +: SEG] = w_seg_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_carry <= w_carry_out;
            r_ovf   <= w_carry_msb ^ w_carry_out;
            r_x     <= w_x_next;
            r_y     <= i_y;
        end
    end

    assign o_valid = r_valid;
    assign o_carry = r_carry;
    assign o_ovf   = r_ovf;
    assign o_x     = r_x;
    assign o_y     = r_y;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: WIDTH split into SEG-bit segments, one per stage,
// carry registered between stages, valid/ready flow control with whole-pipe stall.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    generate
        if (STAGES < 1) begin : g_bad_cfg
            $error("adder_pipe: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    logic             w_adv;
    logic             w_valid [0:STAGES];
    logic             w_carry [0:STAGES];
    logic [WIDTH-1:0] w_x     [0:STAGES];
    logic [WIDTH-1:0] w_y     [0:STAGES];
    logic             w_ovf   [0:STAGES-1];

    // The whole pipe moves together, so an empty output slot frees every stage.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_x[0]     = in_a;
    assign w_y[0]     = (in_sub == MODE_SUB) ? ~in_b : in_b;
    assign w_carry[0] = (in_sub == MODE_ADD) ? in_cin : 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            adder_pipe_stage #(
                .SEG   (SEG),
                .WIDTH (WIDTH),
                .IDX   (gi)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_adv   (w_adv),
                .i_valid (w_valid[gi]),
                .i_carry (w_carry[gi]),
                .i_x     (w_x[gi]),
                .i_y     (w_y[gi]),
                .o_valid (w_valid[gi+1]),
                .o_carry (w_carry[gi+1]),
                .o_ovf   (w_ovf[gi]),
                .o_x     (w_x[gi+1]),
                .o_y     (w_y[gi+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_sum   = w_x[STAGES];
    assign out_cout  = w_carry[STAGES];
    assign out_ovf   = w_ovf[STAGES-1];
    // Gated by valid so the cleared (all-zero) reset state does not report zero.
    assign out_zero  = out_valid & ~|out_sum;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe at WIDTH=64, SEG=32: vector table plus
// hand-written backpressure and mid-stream reset sequences.
module tb_adder_pipe;

    localparam int WIDTH = 64;
    localparam int SEG   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_chk  = 0;

    function automatic vec_t mk(string n, logic [63:0] a, logic [63:0] b,
                                logic cin, logic sub, logic [63:0] s,
                                logic c, logic o, logic z);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = s; v.cout = c; v.ovf = o; v.zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({v.name, ".early_valid"}, 64'(out_valid), 64'd0);
        tick();
        chk({v.name, ".valid"}, 64'(out_valid), 64'd1);
        chk({v.name, ".sum"},   out_sum,         v.sum);
        chk({v.name, ".cout"},  64'(out_cout),   64'(v.cout));
        chk({v.name, ".ovf"},   64'(out_ovf),    64'(v.ovf));
        chk({v.name, ".zero"},  64'(out_zero),   64'(v.zero));
        n_vec++;
        $display("vec %-12s a=%h b=%h sub=%0b cin=%0b -> sum=%h c=%0b v=%0b z=%0b",
                 v.name, v.a, v.b, v.sub, v.cin, out_sum, out_cout, out_ovf, out_zero);
        tick();
    endtask

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] held;
        int          sent;
        int          recv;

        vecs.push_back(mk("add_xseg",  64'h0000_0000_FFFF_FFFF, 64'h1, 0, 0, 64'h0000_0001_0000_0000, 0, 0, 0));
        vecs.push_back(mk("add_full",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 1));
        vecs.push_back(mk("add_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h8000_0000_0000_0000, 0, 1, 0));
        vecs.push_back(mk("sub_5m7",   64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk("sub_minm1", 64'h8000_0000_0000_0000, 64'h1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0));
        vecs.push_back(mk("sub_cin1",  64'd5, 64'd7, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk("add_cin1",  64'h0000_0000_FFFF_FFFF, 64'h0, 1, 0, 64'h0000_0001_0000_0000, 0, 0, 0));
        vecs.push_back(mk("sub_eq",    64'd7, 64'd7, 0, 1, 64'h0, 1, 0, 1));
        vecs.push_back(mk("add_negov", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 64'h0, 1, 1, 1));
        vecs.push_back(mk("add_mixed", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0, 64'h2345_6789_ABCD_F001, 0, 0, 0));
        vecs.push_back(mk("sub_xseg",  64'h0000_0001_0000_0000, 64'h1, 0, 1, 64'h0000_0000_FFFF_FFFF, 1, 0, 0));

        // Reset
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.out_sum",   out_sum,        64'd0);
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.flags",     {61'd0, out_cout, out_ovf, out_zero}, 64'd0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: 4 beats, consumer stalls on cycles 3..5
        sent = 0; recv = 0; held = '0;
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(2 * i + 1000));
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 4);
            in_a      = 64'(sent + 1000);
            in_b      = 64'(sent);
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                chk($sformatf("bp.in_ready_stall%0d", cyc), 64'(in_ready), 64'd0);
                if (cyc == 3) held = out_sum;
                else chk($sformatf("bp.hold%0d", cyc), out_sum, held);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (recv < 4) begin
                    chk($sformatf("bp.beat%0d", recv), out_sum, exp_q[recv]);
                    n_vec++;
                    $display("bp  beat %0d out_sum=%0d (cycle %0d)", recv, out_sum, cyc);
                end else begin
                    chk("bp.extra_beat", 64'(recv), 64'd4);
                end
                recv++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp.sent", 64'(sent), 64'd4);
        chk("bp.recv", 64'(recv), 64'd4);

        // Reset with two beats in flight
        in_valid = 1'b1; in_a = 64'd111; in_b = 64'd222; in_sub = 1'b0; in_cin = 1'b0;
        tick();
        in_a = 64'd333; in_b = 64'd444;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.out_valid0", 64'(out_valid), 64'd0);
        tick();
        chk("rst_mid.out_valid1", 64'(out_valid), 64'd0);
        tick();
        chk("rst_mid.out_valid2", 64'(out_valid), 64'd0);
        $display("rst_mid in-flight beats discarded");
        run_vec(mk("post_rst", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 0, 0,
                   64'h0000_0000_0000_0030, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
